aquila_device_axi_bridge: RTL and testbench
===========================================

Name: aquila_device_axi_bridge

Overview:
- Converts the Aquila uncached device master port (M_DEVICE_*, region 0xC000_0000–0xCFFF_FFFF) into a single-outstanding AXI4-Lite master transaction.
- Sits directly downstream of the Aquila top-level wrapper and in front of the SoC AXI interconnect that feeds the UART, GPIO and timer peripherals.
- Performs one request at a time. Returns a one-cycle ready pulse to the core. Records AXI error responses in a sticky error flag.

Parameters:
- XLEN, 32, data/address width; must be 32.
- ERR_RDATA, 32'hDEAD_BEEF, read data returned to the core when RRESP is an error.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous, active-low reset
- S_DEVICE_strobe_i  in  1  one-cycle request pulse from core
- S_DEVICE_addr_i  in  XLEN  request address
- S_DEVICE_rw_i  in  1  1=write, 0=read
- S_DEVICE_byte_enable_i  in  XLEN/8  write byte strobes
- S_DEVICE_data_i  in  XLEN  write data
- S_DEVICE_data_ready_o  out  1  one-cycle completion pulse
- S_DEVICE_data_o  out  XLEN  read data, held until next completion
- err_o  out  1  sticky: set on any non-OKAY BRESP/RRESP
- err_addr_o  out  XLEN  address of the first errored transaction since clear
- err_clr_i  in  1  clears err_o
- m_axi_awaddr/awprot/awvalid/awready  out/out/out/in  XLEN/3/1/1  AW channel
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  XLEN/XLEN/8/1/1  W channel
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel
- m_axi_araddr/arprot/arvalid/arready  out/out/out/in  XLEN/3/1/1  AR channel
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  XLEN/2/1/1  R channel

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - FSM=IDLE.
  - All valid/ready outputs low.
  - S_DEVICE_data_ready_o=0, S_DEVICE_data_o=0, err_o=0, err_addr_o=0.
  - awprot=arprot=3'b000 constant.
  - Reset mid-transaction abandons the transaction; no completion pulse is issued.
- FSM states: IDLE, WRITE, WRESP, READ, RDATA, DONE.
- IDLE:
  - On strobe, latch addr, rw, byte_enable and data into internal registers.
  - If rw=1, go to WRITE: awvalid=wvalid=1 on the next cycle.
  - If rw=0, go to READ: arvalid=1 on the next cycle.
  - Strobes in any non-IDLE state are ignored; the core never issues them.
- WRITE:
  - AW and W are independent.
  - awvalid drops the cycle after awvalid&&awready; wvalid drops the cycle after wvalid&&wready.
  - Either order and simultaneous handshakes are legal.
  - When both are done, go to WRESP.
  - Valids never deassert before their handshake. Addr/data/strb are stable while valid.
- WRESP: bready=1. On bvalid, go to DONE; if bresp!=0, set the error.
- READ: arvalid=1 until arready, then go to RDATA.
- RDATA:
  - rready=1. On rvalid, capture into S_DEVICE_data_o: rdata if rresp==0, else ERR_RDATA (and set the error).
  - Go to DONE.
- DONE: S_DEVICE_data_ready_o=1 for exactly one cycle; return to IDLE.
- S_DEVICE_data_o changes only on read completion. Writes leave it unchanged.
- Minimum latency (all slaves ready immediately):
  - strobe at cycle 0, AW/W handshake at cycle 1, B at cycle 2, ready at cycle 3.
  - Reads have the same latency.
  - This exceeds the core-side one-cycle select delay.
- Error capture:
  - err_addr_o loads only when err_o is currently 0, so the first error is kept.
  - err_clr_i clears err_o. If an error event occurs in the same cycle, set wins and err_addr_o reloads.

Test Plan:
- Write 0xC000_0004 data 0x1234_5678 be 4'b0011, slave always ready:
  - awaddr=0xC000_0004, wstrb=0x3, wdata as given.
  - data_ready pulse at cycle 3 only; data_o unchanged.
- Read 0xC000_0010, slave returns rdata 0xA5A5_0001 with arready delayed 4 cycles and rvalid delayed 3 more:
  - arvalid held high all 5 cycles; data_o=0xA5A5_0001.
  - Single ready pulse one cycle after the R handshake.
- Write with wready delayed 6 cycles, awready immediate:
  - awvalid drops after 1 cycle; wvalid held 7 cycles.
  - bready asserted only after both handshakes.
- Read returning rresp=2'b10 at 0xC000_0020:
  - data_o=0xDEAD_BEEF, err_o=1, err_addr_o=0xC000_0020.
  - A second error at 0xC000_0030 leaves err_addr_o unchanged.
  - err_clr_i clears err_o.
- Assert rst_ni low while in WRESP:
  - All valids and bready go low immediately (asynchronously).
  - No ready pulse.
  - After release, a new read completes normally.

Source files
------------

// File: rtl/aquila_device_axi_bridge.sv
// Bridges the Aquila uncached device port onto a single-outstanding AXI4-Lite master.
// One request at a time; sticky error flag captures the first failing address.
module aquila_device_axi_bridge #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                S_DEVICE_strobe_i,
  input  logic [XLEN-1:0]     S_DEVICE_addr_i,
  input  logic                S_DEVICE_rw_i,
  input  logic [XLEN/8-1:0]   S_DEVICE_byte_enable_i,
  input  logic [XLEN-1:0]     S_DEVICE_data_i,
  output logic                S_DEVICE_data_ready_o,
  output logic [XLEN-1:0]     S_DEVICE_data_o,
  output logic                err_o,
  output logic [XLEN-1:0]     err_addr_o,
  input  logic                err_clr_i,
  output logic [XLEN-1:0]     m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [XLEN-1:0]     m_axi_wdata,
  output logic [XLEN/8-1:0]   m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [XLEN-1:0]     m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [XLEN-1:0]     m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StWresp,
    StRead,
    StRdata,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic [XLEN/8-1:0]   be_q, be_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [XLEN-1:0]     err_addr_q, err_addr_d;
  logic                err_set;

  // All handshake outputs decode from registered state so reset drops them at once.
  assign m_axi_awvalid         = (state_q == StWrite) && !aw_done_q;
  assign m_axi_wvalid          = (state_q == StWrite) && !w_done_q;
  assign m_axi_bready          = (state_q == StWresp);
  assign m_axi_arvalid         = (state_q == StRead);
  assign m_axi_rready          = (state_q == StRdata);
  assign S_DEVICE_data_ready_o = (state_q == StDone);

  assign m_axi_awaddr    = addr_q;
  assign m_axi_araddr    = addr_q;
  assign m_axi_wdata     = wdata_q;
  assign m_axi_wstrb     = be_q;
  assign m_axi_awprot    = 3'b000;
  assign m_axi_arprot    = 3'b000;
  assign S_DEVICE_data_o = rdata_q;
  assign err_o           = err_q;
  assign err_addr_o      = err_addr_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_set   = 1'b0;

    case (state_q)
      StIdle: begin
        if (S_DEVICE_strobe_i) begin
          addr_d    = S_DEVICE_addr_i;
          be_d      = S_DEVICE_byte_enable_i;
          wdata_d   = S_DEVICE_data_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_DEVICE_rw_i ? StWrite : StRead;
        end
      end
      StWrite: begin
        aw_done_d = aw_done_q | (m_axi_awvalid & m_axi_awready);
        w_done_d  = w_done_q | (m_axi_wvalid & m_axi_wready);
        if (aw_done_d && w_done_d) begin
          state_d = StWresp;
        end
      end
      StWresp: begin
        if (m_axi_bvalid) begin
          err_set = (m_axi_bresp != 2'b00);
          state_d = StDone;
        end
      end
      StRead: begin
        if (m_axi_arready) begin
          state_d = StRdata;
        end
      end
      StRdata: begin
        if (m_axi_rvalid) begin
          err_set = (m_axi_rresp != 2'b00);
          rdata_d = (m_axi_rresp == 2'b00) ? m_axi_rdata : ERR_RDATA;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Set beats clear; a clear in the same cycle as a new error re-arms address capture.
  always_comb begin
    err_d      = err_q;
    err_addr_d = err_addr_q;
    if (err_clr_i) begin
      err_d = 1'b0;
    end
    if (err_set) begin
      err_d = 1'b1;
      if (!err_q || err_clr_i) begin
        err_addr_d = addr_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

endmodule

// File: tb/tb_aquila_device_axi_bridge.sv
// Directed bench for aquila_device_axi_bridge: vector table plus reset-in-WRESP sequence.
module tb_aquila_device_axi_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        strobe = 1'b0;
  logic [31:0] addr = '0;
  logic        rw = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdat = '0;
  logic        data_ready;
  logic [31:0] data_o;
  logic        err_o;
  logic [31:0] err_addr_o;
  logic        err_clr = 1'b0;
  logic [31:0] awaddr, wdata, araddr;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic [31:0] rdata = '0;

  always #5 clk_i = ~clk_i;

  aquila_device_axi_bridge dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .S_DEVICE_strobe_i      (strobe),
    .S_DEVICE_addr_i        (addr),
    .S_DEVICE_rw_i          (rw),
    .S_DEVICE_byte_enable_i (be),
    .S_DEVICE_data_i        (wdat),
    .S_DEVICE_data_ready_o  (data_ready),
    .S_DEVICE_data_o        (data_o),
    .err_o                  (err_o),
    .err_addr_o             (err_addr_o),
    .err_clr_i              (err_clr),
    .m_axi_awaddr           (awaddr),
    .m_axi_awprot           (awprot),
    .m_axi_awvalid          (awvalid),
    .m_axi_awready          (awready),
    .m_axi_wdata            (wdata),
    .m_axi_wstrb            (wstrb),
    .m_axi_wvalid           (wvalid),
    .m_axi_wready           (wready),
    .m_axi_bresp            (bresp),
    .m_axi_bvalid           (bvalid),
    .m_axi_bready           (bready),
    .m_axi_araddr           (araddr),
    .m_axi_arprot           (arprot),
    .m_axi_arvalid          (arvalid),
    .m_axi_arready          (arready),
    .m_axi_rdata            (rdata),
    .m_axi_rresp            (rresp),
    .m_axi_rvalid           (rvalid),
    .m_axi_rready           (rready)
  );

  typedef struct {
    bit          rw;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          aw_dly, w_dly, ar_dly, r_dly, b_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          clr_cyc;
    int          exp_rdy;
    logic [31:0] exp_data;
    logic        exp_err;
    logic [31:0] exp_eaddr;
    int          exp_aw, exp_w, exp_ar;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_fail   = 0;

  // Slave model state
  int aw_dly, w_dly, ar_dly, r_dly, b_dly;
  logic [1:0]  s_resp;
  logic [31:0] s_rdata, exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;
  int aw_cnt, w_cnt, ar_cnt, r_cnt, b_cnt;
  int aw_cyc, w_cyc, ar_cyc, aw_hs, w_hs, bad;
  bit aw_pend, w_pend, ar_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic reset_slave();
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; r_cnt = 0; b_cnt = 0;
    aw_cyc = 0; w_cyc = 0; ar_cyc = 0; aw_hs = 0; w_hs = 0; bad = 0;
    aw_pend = 0; w_pend = 0; ar_pend = 0;
  endtask

  // One slave step per negedge; readies drive the following posedge.
  task automatic slave_step();
    if (aw_pend && !awvalid) bad++;
    if (w_pend && !wvalid) bad++;
    if (ar_pend && !arvalid) bad++;
    if (awvalid) begin
      aw_cyc++;
      if (awaddr !== exp_addr) bad++;
      awready = (aw_cnt >= aw_dly);
      aw_cnt++;
      if (awready) aw_hs++;
    end else begin
      awready = 1'b0; aw_cnt = 0;
    end
    aw_pend = awvalid && !awready;
    if (wvalid) begin
      w_cyc++;
      if (wdata !== exp_wdata || wstrb !== exp_wstrb) bad++;
      wready = (w_cnt >= w_dly);
      w_cnt++;
      if (wready) w_hs++;
    end else begin
      wready = 1'b0; w_cnt = 0;
    end
    w_pend = wvalid && !wready;
    if (arvalid) begin
      ar_cyc++;
      if (araddr !== exp_addr) bad++;
      arready = (ar_cnt >= ar_dly);
      ar_cnt++;
    end else begin
      arready = 1'b0; ar_cnt = 0;
    end
    ar_pend = arvalid && !arready;
    if (bready) begin
      if (aw_hs == 0 || w_hs == 0) bad++;
      bvalid = (b_cnt >= b_dly);
      bresp  = bvalid ? s_resp : 2'b00;
      b_cnt++;
    end else begin
      bvalid = 1'b0; bresp = 2'b00; b_cnt = 0;
    end
    if (rready) begin
      rvalid = (r_cnt >= r_dly);
      rresp  = rvalid ? s_resp : 2'b00;
      rdata  = rvalid ? s_rdata : 32'h0;
      r_cnt++;
    end else begin
      rvalid = 1'b0; rresp = 2'b00; rdata = 32'h0; r_cnt = 0;
    end
    if (awprot !== 3'b000 || arprot !== 3'b000) bad++;
  endtask

  task automatic tick();
    @(negedge clk_i);
    slave_step();
  endtask

  task automatic setup(input vec_t v);
    aw_dly = v.aw_dly; w_dly = v.w_dly; ar_dly = v.ar_dly; r_dly = v.r_dly; b_dly = v.b_dly;
    s_resp = v.resp; s_rdata = v.rdata;
    exp_addr = v.addr; exp_wdata = v.data; exp_wstrb = v.be;
    reset_slave();
    strobe = 1'b1; addr = v.addr; rw = v.rw; be = v.be; wdat = v.data;
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    int pulses, rcyc;
    v = vecs[idx];
    pulses = 0; rcyc = -1;
    setup(v);
    for (int c = 1; c <= 40; c++) begin
      tick();
      strobe  = 1'b0;
      err_clr = (c == v.clr_cyc);
      if (data_ready) begin
        pulses++;
        rcyc = c;
      end
      if (pulses > 0 && c >= rcyc + 2) break;
    end
    err_clr = 1'b0;
    check($sformatf("v%0d ready_pulses", idx), pulses, 1);
    check($sformatf("v%0d ready_cycle", idx), rcyc, v.exp_rdy);
    check($sformatf("v%0d data_o", idx), data_o, v.exp_data);
    check($sformatf("v%0d err_o", idx), {31'b0, err_o}, {31'b0, v.exp_err});
    check($sformatf("v%0d err_addr", idx), err_addr_o, v.exp_eaddr);
    check($sformatf("v%0d aw_cycles", idx), aw_cyc, v.exp_aw);
    check($sformatf("v%0d w_cycles", idx), w_cyc, v.exp_w);
    check($sformatf("v%0d ar_cycles", idx), ar_cyc, v.exp_ar);
    check($sformatf("v%0d protocol", idx), bad, 0);
  endtask

  initial begin
    int pulses;
    //          rw addr          data          be    aw w ar r b resp  rdata        clr rdy data          err eaddr         aw w ar
    vecs[0] = '{1, 32'hC000_0004, 32'h1234_5678, 4'h3, 0, 0, 0, 0, 0, 2'b00, 32'h0,        -1, 3, 32'h0,         0, 32'h0,         1, 1, 0};
    vecs[1] = '{0, 32'hC000_0010, 32'h0,         4'h0, 0, 0, 4, 3, 0, 2'b00, 32'hA5A5_0001, -1, 10, 32'hA5A5_0001, 0, 32'h0,        0, 0, 5};
    vecs[2] = '{1, 32'hC000_0008, 32'hCAFE_F00D, 4'hF, 0, 6, 0, 0, 0, 2'b00, 32'h0,        -1, 9, 32'hA5A5_0001, 0, 32'h0,         1, 7, 0};
    vecs[3] = '{1, 32'hC000_000C, 32'h0000_00FF, 4'h8, 3, 1, 0, 0, 2, 2'b00, 32'h0,        -1, 8, 32'hA5A5_0001, 0, 32'h0,         4, 2, 0};
    vecs[4] = '{0, 32'hC000_0020, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b10, 32'h1111_1111, -1, 3, 32'hDEAD_BEEF, 1, 32'hC000_0020, 0, 0, 1};
    vecs[5] = '{1, 32'hC000_0030, 32'h5555_AAAA, 4'hF, 0, 0, 0, 0, 0, 2'b10, 32'h0,        -1, 3, 32'hDEAD_BEEF, 1, 32'hC000_0020, 1, 1, 0};
    vecs[6] = '{0, 32'hC000_0040, 32'h0,         4'h0, 0, 0, 0, 1, 0, 2'b00, 32'h0BAD_F00D,  1, 4, 32'h0BAD_F00D, 0, 32'hC000_0020, 0, 0, 1};
    vecs[7] = '{0, 32'hC000_0050, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h2222_2222, -1, 3, 32'hDEAD_BEEF, 1, 32'hC000_0050, 0, 0, 1};
    vecs[8] = '{0, 32'hC000_0060, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b10, 32'h3333_3333,  2, 3, 32'hDEAD_BEEF, 1, 32'hC000_0060, 0, 0, 1};
    vecs[9] = '{0, 32'hC000_0070, 32'h0,         4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h7777_0000, -1, 3, 32'h7777_0000, 0, 32'h0,        0, 0, 1};

    reset_slave();
    repeat (3) @(negedge clk_i);
    check("reset valids", {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    check("reset ready", {31'b0, data_ready}, 32'h0);
    check("reset data_o", data_o, 32'h0);
    check("reset err", {31'b0, err_o}, 32'h0);
    check("reset err_addr", err_addr_o, 32'h0);
    check("reset prot", {26'b0, awprot, arprot}, 32'h0);
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset while waiting for B: everything drops asynchronously, no completion follows.
    setup('{1, 32'hC000_0080, 32'h0F0F_0F0F, 4'hF, 0, 0, 0, 0, 20, 2'b00, 32'h0, -1, 0,
            32'h0, 0, 32'h0, 0, 0, 0});
    pulses = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      strobe = 1'b0;
      if (data_ready) pulses++;
    end
    check("pre-reset bready", {31'b0, bready}, 32'h1);
    #2 rst_ni = 1'b0;
    #1;
    check("async reset valids", {27'b0, awvalid, wvalid, bready, arvalid, rready}, 32'h0);
    check("async reset ready", {31'b0, data_ready}, 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      if (data_ready) pulses++;
    end
    rst_ni = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (data_ready) pulses++;
    end
    check("reset no pulse", pulses, 0);
    check("post-reset data_o", data_o, 32'h0);
    check("post-reset err", {31'b0, err_o}, 32'h0);

    run_vec(9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
